// File: rtl/dmem_arb_pkg.sv
// Shared types and default widths for the data-memory arbiter.
// Optional round-robin arbitration is enabled by defining DMEM_ARB_RR_EN.
package dmem_arb_pkg;

    localparam int DMEM_DATA_W = 32;
    localparam int DMEM_ADDR_W = 9;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RDATA  = 2'd2
    } arb_state_t;

    typedef enum logic {
        CORE = 1'b0,
        DBG  = 1'b1
    } owner_t;

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational owner selection between the core and debug ports.
// DMEM_ARB_RR_EN selects round-robin on contention; otherwise the core always wins.
module dmem_arb_pick
    import dmem_arb_pkg::*;
(
    input  logic   core_req,
    input  logic   dbg_req,
    input  owner_t last_owner,
    output owner_t owner
);

`ifdef DMEM_ARB_RR_EN
    always_comb begin
        owner = CORE;
        if (core_req && dbg_req) begin
            // The port that was not granted most recently takes the tie.
            owner = (last_owner == CORE) ? DBG : CORE;
        end else if (dbg_req) begin
            owner = DBG;
        end
    end
`else
    logic unused_last_owner;
    assign unused_last_owner = last_owner;

    always_comb begin
        owner = CORE;
        if (!core_req && dbg_req) begin
            owner = DBG;
        end
    end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port (core / debug) arbiter in front of a single-ported data memory.
// Define DMEM_ARB_RR_EN for round-robin contention handling instead of core priority.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DATA_W = DMEM_DATA_W,
    parameter int ADDR_W = DMEM_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_gnt,
    output logic              core_rvalid,
    output logic [DATA_W-1:0] core_rdata,
    output logic              core_stall,

    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,

    output logic              mem_wr,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic [15:0]       conflict_cnt
);

    arb_state_t        state;
    arb_state_t        state_nxt;
    logic              load_txn;

    owner_t            pick_owner;
    owner_t            last_owner;
    owner_t            owner_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    logic [DATA_W-1:0] core_rdata_q;
    logic [DATA_W-1:0] dbg_rdata_q;
    logic [15:0]       conflict_q;
    logic              contended;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    dmem_arb_pick u_pick (
        .core_req   (core_req),
        .dbg_req    (dbg_req),
        .last_owner (last_owner),
        .owner      (pick_owner)
    );

    assign sel_we    = (pick_owner == DBG) ? dbg_we    : core_we;
    assign sel_addr  = (pick_owner == DBG) ? dbg_addr  : core_addr;
    assign sel_wdata = (pick_owner == DBG) ? dbg_wdata : core_wdata;

    assign contended = (state == IDLE) && core_req && dbg_req;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        load_txn    = 1'b0;
        core_gnt    = 1'b0;
        dbg_gnt     = 1'b0;
        core_rvalid = 1'b0;
        dbg_rvalid  = 1'b0;
        mem_wr      = 1'b0;
        mem_rd      = 1'b0;
        case (state)
            IDLE: begin
                if (core_req || dbg_req) begin
                    load_txn  = 1'b1;
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                mem_wr    = we_q;
                mem_rd    = ~we_q;
                core_gnt  = (owner_q == CORE);
                dbg_gnt   = (owner_q == DBG);
                state_nxt = we_q ? IDLE : RDATA;
            end
            RDATA: begin
                core_rvalid = (owner_q == CORE);
                dbg_rvalid  = (owner_q == DBG);
                state_nxt   = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Payload is captured once in IDLE so later request changes cannot disturb it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner_q <= CORE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (load_txn) begin
            owner_q <= pick_owner;
            we_q    <= sel_we;
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
        end
    end

`ifdef DMEM_ARB_RR_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_owner <= DBG;
        end else if (load_txn) begin
            last_owner <= pick_owner;
        end
    end
`else
    assign last_owner = DBG;
`endif

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    // Read data is forwarded in the RDATA cycle and held afterwards.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            core_rdata_q <= '0;
            dbg_rdata_q  <= '0;
        end else begin
            if (core_rvalid) begin
                core_rdata_q <= mem_rdata;
            end
            if (dbg_rvalid) begin
                dbg_rdata_q <= mem_rdata;
            end
        end
    end

    assign core_rdata = core_rvalid ? mem_rdata : core_rdata_q;
    assign dbg_rdata  = dbg_rvalid  ? mem_rdata : dbg_rdata_q;

    assign core_stall = core_req && !core_gnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            conflict_q <= 16'h0000;
        end else if (contended) begin
            conflict_q <= sat_inc(conflict_q);
        end
    end

    assign conflict_cnt = conflict_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus random single-port traffic
// against a transaction-level memory/arbitration model.
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    localparam int DW = 32;
    localparam int AW = 9;

    logic          clk;
    logic          reset;
    logic          core_req, core_we;
    logic [AW-1:0] core_addr;
    logic [DW-1:0] core_wdata;
    logic          core_gnt, core_rvalid, core_stall;
    logic [DW-1:0] core_rdata;
    logic          dbg_req, dbg_we;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_wdata;
    logic          dbg_gnt, dbg_rvalid;
    logic [DW-1:0] dbg_rdata;
    logic          mem_wr, mem_rd;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic [15:0]   conflict_cnt;

    bit [DW-1:0]   mem     [512];
    bit [DW-1:0]   ref_mem [512];

    int            checks;
    int            errors;
    bit            last_dbg;
    logic [DW-1:0] exp_core_rdata;
    logic [DW-1:0] exp_dbg_rdata;
    int            exp_conflict;

    dmem_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .core_req     (core_req),
        .core_we      (core_we),
        .core_addr    (core_addr),
        .core_wdata   (core_wdata),
        .core_gnt     (core_gnt),
        .core_rvalid  (core_rvalid),
        .core_rdata   (core_rdata),
        .core_stall   (core_stall),
        .dbg_req      (dbg_req),
        .dbg_we       (dbg_we),
        .dbg_addr     (dbg_addr),
        .dbg_wdata    (dbg_wdata),
        .dbg_gnt      (dbg_gnt),
        .dbg_rvalid   (dbg_rvalid),
        .dbg_rdata    (dbg_rdata),
        .mem_wr       (mem_wr),
        .mem_rd       (mem_rd),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .conflict_cnt (conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous single-port memory: read data appears the cycle after mem_rd.
    always @(posedge clk) begin
        if (mem_wr) mem[mem_addr] <= mem_wdata;
        if (mem_rd) mem_rdata <= mem[mem_addr];
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit winner_dbg();
`ifdef DMEM_ARB_RR_EN
        return !last_dbg;
`else
        return 1'b0;
`endif
    endfunction

    task automatic set_port(input bit dbg, input bit req, input bit we,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (dbg) begin
            dbg_req = req; dbg_we = we; dbg_addr = a; dbg_wdata = d;
        end else begin
            core_req = req; core_we = we; core_addr = a; core_wdata = d;
        end
    endtask

    task automatic check_reset_outputs(input string where);
        check({where, "_strobes"},
              64'({core_gnt, core_rvalid, dbg_gnt, dbg_rvalid, mem_wr, mem_rd, core_stall}), 64'd0);
        check({where, "_rdata"}, 64'({core_rdata, dbg_rdata}), 64'd0);
        check({where, "_mem_bus"}, 64'({mem_addr, mem_wdata}), 64'd0);
        check({where, "_conflict"}, 64'(conflict_cnt), 64'd0);
    endtask

    task automatic clear_model();
        exp_core_rdata = '0;
        exp_dbg_rdata  = '0;
        exp_conflict   = 0;
        last_dbg       = 1'b1;
    endtask

    // One uncontended transaction starting from IDLE.
    task automatic txn(input bit dbg, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        check("hold_core_rdata", 64'(core_rdata), 64'(exp_core_rdata));
        check("hold_dbg_rdata", 64'(dbg_rdata), 64'(exp_dbg_rdata));
        set_port(dbg, 1'b1, we, a, d);
        @(negedge clk);
        check("gnt_owner", 64'(dbg ? dbg_gnt : core_gnt), 64'd1);
        check("gnt_other", 64'(dbg ? core_gnt : dbg_gnt), 64'd0);
        check("mem_strobes", 64'({mem_wr, mem_rd}), 64'({we, ~we}));
        check("mem_addr", 64'(mem_addr), 64'(a));
        if (we) check("mem_wdata", 64'(mem_wdata), 64'(d));
        if (!dbg) check("stall_in_gnt", 64'(core_stall), 64'd0);
        set_port(dbg, 1'b0, 1'b0, '0, '0);
        last_dbg = dbg;
        if (we) begin
            ref_mem[a] = d;
        end else begin
            @(negedge clk);
            check("rvalid_owner", 64'(dbg ? dbg_rvalid : core_rvalid), 64'd1);
            check("rvalid_other", 64'(dbg ? core_rvalid : dbg_rvalid), 64'd0);
            check("rdata", 64'(dbg ? dbg_rdata : core_rdata), 64'(ref_mem[a]));
            if (dbg) exp_dbg_rdata = ref_mem[a];
            else     exp_core_rdata = ref_mem[a];
        end
    endtask

    // Both ports hold write requests until n grants have been observed.
    task automatic contend_writes(input int n, input logic [AW-1:0] ca, input logic [AW-1:0] da);
        logic [DW-1:0] cd;
        logic [DW-1:0] dd;
        bit            w;
        cd = $urandom;
        dd = $urandom;
        @(negedge clk);
        set_port(1'b0, 1'b1, 1'b1, ca, cd);
        set_port(1'b1, 1'b1, 1'b1, da, dd);
        for (int g = 0; g < n; g++) begin
            w = winner_dbg();
            @(negedge clk);
            check("cont_gnt_core", 64'(core_gnt), 64'(!w));
            check("cont_gnt_dbg", 64'(dbg_gnt), 64'(w));
            check("cont_stall", 64'(core_stall), 64'(w));
            exp_conflict = (exp_conflict >= 65535) ? 65535 : exp_conflict + 1;
            last_dbg = w;
            if (w) ref_mem[da] = dd;
            else   ref_mem[ca] = cd;
            @(negedge clk);
            check("cont_idle_gnt", 64'({core_gnt, dbg_gnt}), 64'd0);
            check("cont_idle_stall", 64'(core_stall), 64'd1);
        end
        set_port(1'b0, 1'b0, 1'b0, '0, '0);
        set_port(1'b1, 1'b0, 1'b0, '0, '0);
        check("cont_conflict_cnt", 64'(conflict_cnt), 64'(exp_conflict));
    endtask

    initial begin
        bit            b_dbg;
        bit            b_we;
        bit            w;
        logic [AW-1:0] ra;
        logic [AW-1:0] rb;
        logic [AW-1:0] ra_w;
        logic [AW-1:0] ra_l;
        int            exp_sat;

        checks = 0;
        errors = 0;
        clear_model();
        reset = 1'b0;
        set_port(1'b0, 1'b0, 1'b0, '0, '0);
        set_port(1'b1, 1'b0, 1'b0, '0, '0);

        // Reset state
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b1;

        // Core store then load of the same word
        txn(1'b0, 1'b1, 9'h010, 32'hDEADBEEF);
        txn(1'b0, 1'b0, 9'h010, 32'h0);
        check("deadbeef_hold", 64'(core_rdata), 64'h0000_0000_DEAD_BEEF);

        // Random single-port traffic over a small address window
        for (int i = 0; i < 30; i++) begin
            b_dbg = 1'($urandom_range(0, 1));
            b_we  = 1'($urandom_range(0, 1));
            txn(b_dbg, b_we, 9'($urandom_range(0, 15)), $urandom);
        end

        // Simultaneous reads: winner first, loser three cycles later
        ra = 9'h003;
        rb = 9'h00C;
        @(negedge clk);
        set_port(1'b0, 1'b1, 1'b0, ra, '0);
        set_port(1'b1, 1'b1, 1'b0, rb, '0);
        w    = winner_dbg();
        ra_w = w ? rb : ra;
        ra_l = w ? ra : rb;
        @(negedge clk);
        check("both_gnt_core", 64'(core_gnt), 64'(!w));
        check("both_gnt_dbg", 64'(dbg_gnt), 64'(w));
        check("both_mem_addr", 64'(mem_addr), 64'(ra_w));
        exp_conflict++;
        check("both_conflict", 64'(conflict_cnt), 64'(exp_conflict));
        set_port(w, 1'b0, 1'b0, '0, '0);
        last_dbg = w;
        @(negedge clk);
        check("both_rvalid_win", 64'(w ? dbg_rvalid : core_rvalid), 64'd1);
        check("both_rvalid_lose", 64'(w ? core_rvalid : dbg_rvalid), 64'd0);
        check("both_rdata_win", 64'(w ? dbg_rdata : core_rdata), 64'(ref_mem[ra_w]));
        if (w) exp_dbg_rdata = ref_mem[ra_w]; else exp_core_rdata = ref_mem[ra_w];
        @(negedge clk);
        check("both_idle_gnt", 64'({core_gnt, dbg_gnt}), 64'd0);
        @(negedge clk);
        check("both_gnt_late", 64'(w ? core_gnt : dbg_gnt), 64'd1);
        check("both_mem_addr_late", 64'(mem_addr), 64'(ra_l));
        set_port(!w, 1'b0, 1'b0, '0, '0);
        last_dbg = !w;
        @(negedge clk);
        check("both_rdata_late", 64'(w ? core_rdata : dbg_rdata), 64'(ref_mem[ra_l]));
        if (w) exp_core_rdata = ref_mem[ra_l]; else exp_dbg_rdata = ref_mem[ra_l];
        check("both_conflict_after", 64'(conflict_cnt), 64'(exp_conflict));

        // Continuous contention for eight write grants
        contend_writes(8, 9'h020, 9'h021);

        // Core request during a debug read: stalled until its own grant
        txn(1'b1, 1'b1, 9'h030, 32'h5A5A_1234);
        @(negedge clk);
        set_port(1'b1, 1'b1, 1'b0, 9'h030, '0);
        @(negedge clk);
        check("stall_dbg_gnt", 64'(dbg_gnt), 64'd1);
        set_port(1'b1, 1'b0, 1'b0, '0, '0);
        set_port(1'b0, 1'b1, 1'b1, 9'h031, 32'h0BAD_F00D);
        #1;
        check("stall_in_access", 64'(core_stall), 64'd1);
        @(negedge clk);
        check("stall_rvalid_dbg", 64'(dbg_rvalid), 64'd1);
        check("stall_rdata_dbg", 64'(dbg_rdata), 64'h5A5A_1234);
        exp_dbg_rdata = 32'h5A5A_1234;
        check("stall_in_rdata", 64'(core_stall), 64'd1);
        @(negedge clk);
        check("stall_in_idle", 64'(core_stall), 64'd1);
        @(negedge clk);
        check("stall_core_gnt", 64'(core_gnt), 64'd1);
        check("stall_clear", 64'(core_stall), 64'd0);
        set_port(1'b0, 1'b0, 1'b0, '0, '0);
        ref_mem[9'h031] = 32'h0BAD_F00D;
        last_dbg = 1'b0;

        // Reset while a debug read is in ACCESS
        @(negedge clk);
        set_port(1'b1, 1'b1, 1'b0, 9'h030, '0);
        @(negedge clk);
        check("rst_acc_gnt", 64'(dbg_gnt), 64'd1);
        set_port(1'b1, 1'b0, 1'b0, '0, '0);
        reset = 1'b0;
        #1;
        check_reset_outputs("rst_access");
        clear_model();
        @(negedge clk);
        check("rst_acc_no_rvalid", 64'(dbg_rvalid), 64'd0);
        reset = 1'b1;
        @(negedge clk);
        check("rst_acc_no_rvalid2", 64'({dbg_rvalid, dbg_gnt}), 64'd0);

        // Reset while a debug read is in RDATA
        txn(1'b1, 1'b1, 9'h1A5, 32'hC0FF_EE11);
        txn(1'b1, 1'b0, 9'h1A5, 32'h0);
        @(negedge clk);
        set_port(1'b1, 1'b1, 1'b0, 9'h030, '0);
        @(negedge clk);
        check("rst_rd_gnt", 64'(dbg_gnt), 64'd1);
        set_port(1'b1, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_reset_outputs("rst_rdata");
        clear_model();
        @(negedge clk);
        check("rst_rd_no_rvalid", 64'(dbg_rvalid), 64'd0);
        reset = 1'b1;
        txn(1'b1, 1'b0, 9'h031, 32'h0);

        // Saturation of the contention counter with the FSM held in IDLE
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        clear_model();
        set_port(1'b0, 1'b1, 1'b1, 9'h040, 32'h1);
        set_port(1'b1, 1'b1, 1'b1, 9'h041, 32'h2);
        force dut.state = IDLE;
        for (int n = 1; n <= 70000; n++) begin
            @(negedge clk);
            if (n == 1 || n == 65534 || n == 65535 || n == 70000) begin
                exp_sat = (n > 65535) ? 65535 : n;
                check("sat_conflict", 64'(conflict_cnt), 64'(exp_sat));
            end
        end
        set_port(1'b0, 1'b0, 1'b0, '0, '0);
        set_port(1'b1, 1'b0, 1'b0, '0, '0);
        release dut.state;
        reset = 1'b0;
        #1;
        check_reset_outputs("rst_final");
        @(negedge clk);
        reset = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
